// File: rtl/mod6_seq_monitor_pkg.sv
// Shared types and constants for the mod-6 sequence monitor.
// State encoding and counter limits used by the monitor and its helper.
package mod6_seq_monitor_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd5;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/mod6_next.sv
// Combinational mod-6 successor with an out-of-range flag.
// Values 6 and 7 are flagged illegal and map to 0.
module mod6_next
  import mod6_seq_monitor_pkg::*;
(
  input  logic [CNT_W-1:0] val,
  output logic [CNT_W-1:0] nxt,
  output logic             illegal
);

  always_comb begin
    illegal = (val > CNT_MAX);
    nxt     = (val >= CNT_MAX) ? '0 : val + 3'd1;
  end

endmodule

// File: rtl/mod6_seq_monitor.sv
// Watches a mod-6 counter stream: locks onto it, counts 5->0 wraps,
// and latches a fault on any out-of-sequence sample until cleared.
module mod6_seq_monitor
  import mod6_seq_monitor_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_ovf,
  output logic              err,
  output logic              err_sticky
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic              locked_q, locked_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_ovf_q, wrap_ovf_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;

  logic [CNT_W-1:0]  nx_in;
  logic [CNT_W-1:0]  nx_out;
  logic              nx_ill;
  logic [WRAP_W:0]   wrap_inc;

  // One helper serves both states: legality of cnt in SYNC,
  // expected successor of prev in LOCK.
  assign nx_in = (state_q == LOCK) ? prev_q : cnt;

  mod6_next u_next (
    .val     (nx_in),
    .nxt     (nx_out),
    .illegal (nx_ill)
  );

  assign wrap_inc = {1'b0, wrap_cnt_q}
                  + {{WRAP_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_ovf_d   = wrap_ovf_q;
    err_sticky_d = err_sticky_q;
    wrap_pulse_d = 1'b0;
    err_d        = 1'b0;
    if (clr) begin
      state_d      = SYNC;
      wrap_cnt_d   = '0;
      wrap_ovf_d   = 1'b0;
      err_sticky_d = 1'b0;
    end else if (en) begin
      case (state_q)
        SYNC: begin
          if (nx_ill) begin
            state_d      = FAULT;
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
          end else begin
            prev_d  = cnt;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (cnt == nx_out) begin
            prev_d = cnt;
            if (prev_q == CNT_MAX) begin
              wrap_pulse_d = 1'b1;
              wrap_cnt_d   = wrap_inc[WRAP_W-1:0];
              wrap_ovf_d   = wrap_ovf_q | wrap_inc[WRAP_W];
            end
          end else begin
            state_d      = FAULT;
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
          end
        end
        FAULT: ;
        default: state_d = SYNC;
      endcase
    end else if (!(state_q inside {SYNC, LOCK, FAULT})) begin
      state_d = SYNC;
    end
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SYNC;
      prev_q       <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      wrap_ovf_q   <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_ovf_q   <= wrap_ovf_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign wrap_ovf   = wrap_ovf_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mod6_seq_monitor.sv
// Bench for mod6_seq_monitor: directed scenarios plus random traffic,
// two widths in parallel against a wrap-total reference model.
module tb_mod6_seq_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] cnt;
  logic       clr;

  logic       lk8, wp8, ov8, er8, es8;
  logic [7:0] wc8;
  logic       lk2, wp2, ov2, er2, es2;
  logic [1:0] wc2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: total wraps since clear is kept unbounded,
  // the width-limited count and overflow are derived from it.
  bit m_lock   = 0;
  bit m_fault  = 0;
  bit m_sticky = 0;
  bit m_wp     = 0;
  bit m_err    = 0;
  int m_prev   = 0;
  int m_wraps  = 0;

  mod6_seq_monitor u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cnt        (cnt),
    .clr        (clr),
    .locked     (lk8),
    .wrap_pulse (wp8),
    .wrap_cnt   (wc8),
    .wrap_ovf   (ov8),
    .err        (er8),
    .err_sticky (es8)
  );

  mod6_seq_monitor #(.WRAP_W(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cnt        (cnt),
    .clr        (clr),
    .locked     (lk2),
    .wrap_pulse (wp2),
    .wrap_cnt   (wc2),
    .wrap_ovf   (ov2),
    .err        (er2),
    .err_sticky (es2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lock = 0; m_fault = 0; m_sticky = 0;
      m_wp = 0; m_err = 0; m_prev = 0; m_wraps = 0;
    end else begin
      m_wp = 0;
      m_err = 0;
      if (clr) begin
        m_lock = 0; m_fault = 0;
        m_wraps = 0; m_sticky = 0;
      end else if (en && !m_fault) begin
        if (!m_lock) begin
          if (cnt <= 5) begin
            m_prev = cnt;
            m_lock = 1;
          end else begin
            m_fault = 1; m_err = 1; m_sticky = 1;
          end
        end else if (int'(cnt) == (m_prev + 1) % 6) begin
          if (cnt == 0) begin
            m_wp = 1;
            m_wraps++;
          end
          m_prev = cnt;
        end else begin
          m_lock = 0;
          m_fault = 1; m_err = 1; m_sticky = 1;
        end
      end
    end
    #1;
    chk("locked8", lk8, m_lock);
    chk("wrap_pulse8", wp8, m_wp);
    chk("wrap_cnt8", wc8, m_wraps % 256);
    chk("wrap_ovf8", ov8, m_wraps >= 256);
    chk("err8", er8, m_err);
    chk("err_sticky8", es8, m_sticky);
    chk("locked2", lk2, m_lock);
    chk("wrap_pulse2", wp2, m_wp);
    chk("wrap_cnt2", wc2, m_wraps % 4);
    chk("wrap_ovf2", ov2, m_wraps >= 4);
    chk("err2", er2, m_err);
    chk("err_sticky2", es2, m_sticky);
  end

  // Called at a falling edge; returns at the next falling edge,
  // by which point the outputs reflect this sample.
  task automatic drv(bit e, bit [2:0] c, bit cl);
    en = e;
    cnt = c;
    clr = cl;
    @(negedge clk);
  endtask

  task automatic run_cycle();
    for (int v = 1; v <= 5; v++) drv(1, 3'(v), 0);
    drv(1, 3'd0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2 [4] = '{1, 2, 3, 0};
    reset = 0; en = 0; cnt = 0; clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_locked", lk8, 0);
    chk("rst_wrap_cnt", wc8, 0);
    chk("rst_sticky", es8, 0);
    reset = 1;

    drv(1, 3'd0, 0);
    chk("lock_first", lk8, 1);
    for (int v = 1; v <= 5; v++) drv(1, 3'(v), 0);
    chk("no_wrap_yet", wp8, 0);
    drv(1, 3'd0, 0);
    chk("wrap_pulse", wp8, 1);
    chk("wrap_cnt_1", wc8, 1);
    drv(1, 3'd1, 0);
    chk("wrap_pulse_end", wp8, 0);
    chk("sticky_clean", es8, 0);

    drv(1, 3'd2, 0);
    drv(1, 3'd4, 0);
    chk("skip_err", er8, 1);
    chk("skip_unlock", lk8, 0);
    chk("skip_sticky", es8, 1);
    drv(1, 3'd3, 0);
    drv(1, 3'd4, 0);
    chk("fault_err_once", er8, 0);
    chk("fault_ignores", lk8, 0);
    chk("fault_wrap_hold", wc8, 1);

    drv(1, 3'd3, 1);
    chk("clr_sticky", es8, 0);
    chk("clr_wrap_cnt", wc8, 0);
    chk("clr_locked", lk8, 0);
    drv(1, 3'd3, 0);
    chk("relock", lk8, 1);

    drv(0, 3'd0, 1);
    drv(1, 3'd0, 0);
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      chk("w2_cnt", wc2, exp2[k]);
      chk("w2_ovf", ov2, k == 3);
    end

    drv(0, 3'd0, 1);
    drv(1, 3'd7, 0);
    chk("sync_ill_err", er8, 1);
    chk("sync_ill_lock", lk8, 0);
    drv(0, 3'd0, 1);
    drv(1, 3'd2, 0);
    drv(1, 3'd3, 0);
    drv(0, 3'd0, 0);
    chk("en0_hold", lk8, 1);
    chk("en0_noerr", er8, 0);
    drv(1, 3'd4, 0);
    chk("en1_resume", lk8, 1);
    chk("en1_noerr", er8, 0);

    drv(0, 3'd0, 1);
    drv(1, 3'd0, 0);
    run_cycle();
    for (int v = 1; v <= 5; v++) drv(1, 3'(v), 0);
    en = 1; cnt = 0; clr = 0;
    #2 reset = 0;
    #1;
    chk("async_wrap_cnt", wc8, 0);
    chk("async_locked", lk8, 0);
    chk("async_pulse", wp8, 0);
    @(negedge clk);
    reset = 1;
    en = 0;
    @(negedge clk);
    chk("post_rst_pulse", wp8, 0);
    chk("post_rst_lock", lk8, 0);

    for (int i = 0; i < 3000; i++) begin
      bit e, cl;
      bit [2:0] c;
      e = $urandom_range(0, 99) < 85;
      cl = $urandom_range(0, 99) < 3;
      if ($urandom_range(0, 99) < 80) c = 3'((m_prev + 1) % 6);
      else c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        en = e; cnt = c; clr = cl;
        #2 reset = 0;
        @(negedge clk);
        reset = 1;
      end else begin
        drv(e, c, cl);
      end
    end

    drv(0, 3'd0, 1);
    drv(1, 3'd0, 0);
    for (int k = 0; k < 257; k++) run_cycle();
    chk("w8_ovf", ov8, 1);
    chk("w8_cnt", wc8, 1);
    drv(0, 3'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod6_seq_monitor.md
MOD6_SEQ_MONITOR -- requirements
Module: mod6_seq_monitor

Interface
REQ-001 Parameter WRAP_W SHALL have default 8 and set the wrap-counter width in bits (legal range 2..16).
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  is asynchronous and active-low: reset=0 SHALL force reset state immediately, and release SHALL take effect on the next clk edge.
REQ-004 Port en  input  1  is the sample strobe; cnt SHALL be evaluated only in cycles where en=1.
REQ-005 Port cnt  input  3  is the count value from the upstream mod-6 counter (legal values 0..5).
REQ-006 Port clr  input  1  is a synchronous clear-and-resync request.
REQ-007 Port locked  output  1  SHALL be 1 exactly while the FSM is in LOCK.
REQ-008 Port wrap_pulse  output  1  is a one-cycle strobe per detected 5->0 transition.
REQ-009 Port wrap_cnt  output  WRAP_W  is the number of wraps detected since the last clear.
REQ-010 Port wrap_ovf  output  1  is sticky and SHALL set when wrap_cnt rolls over from all-ones to 0.
REQ-011 Port err  output  1  is a one-cycle strobe on fault entry.
REQ-012 Port err_sticky  output  1  SHALL be held from fault entry until clr.

Function
REQ-013 FSM states SHALL be SYNC, LOCK and FAULT; the block SHALL hold an internal 3-bit register prev.
REQ-014 All outputs SHALL be registered, with 1-cycle latency from the sampling edge.
REQ-015 SYNC, en=1, cnt<=5: prev<=cnt and next state LOCK; no wrap is counted on this sample.
REQ-016 SYNC, en=1, cnt in {6,7}: next state FAULT, err=1 for one cycle, err_sticky<=1.
REQ-017 LOCK, en=1, cnt==(prev+1) mod 6: prev<=cnt and the FSM SHALL stay in LOCK.
REQ-018 LOCK, en=1, prev==5 and cnt==0: wrap_pulse=1 for one cycle and wrap_cnt<=wrap_cnt+1 modulo 2^WRAP_W.
REQ-019 When wrap_cnt increments from all-ones: wrap_cnt<=0 and wrap_ovf<=1 in the same cycle.
REQ-020 LOCK, en=1, cnt != expected value (including 6 or 7): next state FAULT, err pulse, err_sticky<=1, and wrap_cnt unchanged.
REQ-021 FAULT SHALL ignore en and cnt, hold wrap_cnt, hold wrap_ovf, and hold err_sticky; only clr or reset exits FAULT.
REQ-022 en=0 in any state: state, prev and counters held; wrap_pulse=0 and err=0.
REQ-023 clr=1 SHALL take priority over en in every state: next state SYNC, wrap_cnt<=0, wrap_ovf<=0, err_sticky<=0, pulses 0, and cnt ignored that cycle.
REQ-024 A repeated value (cnt==prev) in LOCK SHALL be treated as a mismatch; the producer holds its count only when en=0.

Reset
REQ-025 On reset=0, state SHALL go to SYNC and prev, locked, wrap_pulse, wrap_cnt, wrap_ovf, err and err_sticky SHALL all go to 0.
REQ-026 Reset asserted mid-operation, including in the same cycle as a wrap or a fault, SHALL override everything; no pulse from that cycle SHALL appear after release.

Structure
REQ-027 A shared package SHALL hold the state encoding (SYNC=2'd0, LOCK=2'd1, FAULT=2'd2), CNT_W=3 and CNT_MAX=5.
REQ-028 The design SHALL be one flat module, except for one natural sub-module mod6_next (combinational: 3-bit value -> (value+1) mod 6, plus an illegal flag for 6/7).
REQ-029 State encoding 2'd3 SHALL be unreachable, and SHALL recover to SYNC on the next edge.

Verification
REQ-030 Release reset, en=1, cnt sequence 0,1,2,3,4,5,0,1 -> locked=1 from the cycle after the first sample; one wrap_pulse; wrap_cnt=1; err_sticky=0.
REQ-031 Locked at prev=2, apply cnt=4 with en=1 -> next cycle err=1, locked=0, err_sticky=1; further samples ignored; wrap_cnt unchanged.
REQ-032 Fault present, assert clr for 1 cycle with en=1 and cnt=3 -> state SYNC with all counters 0; the next en sample of cnt=3 locks.
REQ-033 WRAP_W=2, perform 4 full 0..5 cycles -> wrap_cnt sequence 1,2,3,0; wrap_ovf=1 after the fourth wrap.
REQ-034 In SYNC apply cnt=7 with en=1 -> FAULT with err pulse; then en toggling 1,0,1 while locked with legal steps -> state held during en=0 cycles.
REQ-035 Assert reset=0 asynchronously in the cycle of a 5->0 sample -> all outputs 0 immediately; no wrap_pulse after release.
